imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 195 +++++++++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader and instruction-memory write port.
//
// Accepts a framed little-endian byte stream (LEN_LO, LEN_HI, 4*N data bytes,
// CSUM = XOR of all preceding frame bytes) over a valid/ready handshake,
// packs the data into 32-bit words and writes them to consecutive word
// addresses starting at BASE_ADDR. The core is released from reset only once
// a complete frame with a matching checksum has been loaded.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   s_data       stream byte
//   s_valid      s_data is valid
//   s_ready      loader accepts a byte this cycle (decoded from state only)
//   start        one-cycle pulse re-arming the loader from DONE or ERR
//   imem_we      instruction-memory write enable, one-cycle pulse per word
//   imem_addr    write byte address
//   imem_wdata   write data
//   core_rst_n   active-low core reset, released only in DONE
//   done         load completed successfully
//   err          load failed (length too large or checksum mismatch)
//   words_loaded number of words written in the current frame

module imem_loader #(
    parameter int unsigned               ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR  = '0,
    parameter int unsigned               MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [7:0]              acc_q, acc_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [23:0]             shift_q, shift_d;
    logic [15:0]             words_q, words_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;

    logic                    accept;
    logic                    enter_len0;
    logic [15:0]             len_full;
    logic [ADDR_WIDTH-1:0]   word_offset;

    // Handshake is purely state-decoded so s_ready never depends on s_valid.
    assign s_ready = (state_q == StLen0) || (state_q == StLen1) ||
                     (state_q == StData) || (state_q == StCsum);
    assign accept  = s_valid && s_ready;

    // Length as it stands once LEN_HI is on the bus.
    assign len_full = {s_data, len_q[7:0]};

    // Byte offset of the word being completed; wraps modulo 2^ADDR_WIDTH.
    assign word_offset = ADDR_WIDTH'({words_q, 2'b00});

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        words_d    = words_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_len0 = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d    = StLen0;
                enter_len0 = 1'b1;
            end

            StLen0: begin
                if (accept) begin
                    len_d[7:0] = s_data;
                    acc_d      = acc_q ^ s_data;
                    state_d    = StLen1;
                end
            end

            StLen1: begin
                if (accept) begin
                    len_d = len_full;
                    acc_d = acc_q ^ s_data;
                    if (32'(len_full) > MAX_WORDS) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (accept) begin
                    acc_d      = acc_q ^ s_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word: issue the write.
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + word_offset;
                        wdata_d = {s_data, shift_q};
                        words_d = words_q + 16'd1;
                        if ((words_q + 16'd1) == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        // Shift right so the first byte ends up in [7:0].
                        shift_d = {s_data, shift_q[23:8]};
                    end
                end
            end

            StCsum: begin
                if (accept) begin
                    state_d = (s_data == acc_q) ? StDone : StErr;
                end
            end

            StDone, StErr: begin
                if (start) begin
                    state_d    = StLen0;
                    enter_len0 = 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase

        if (enter_len0) begin
            acc_d      = '0;
            words_d    = '0;
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            acc_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            words_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            words_q    <= words_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign core_rst_n   = (state_q == StDone);
    assign done         = (state_q == StDone);
    assign err          = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of directed frames, hand-written
// reset/start sequences, a MAX_WORDS boundary frame and randomized frames,
// all checked against a frame-level reference model.

module tb_imem_loader;

    localparam int unsigned AW   = 32;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 1024;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          nbytes;
        logic [87:0] bytes;     // byte i at [8*i +: 8]
        int          gap_max;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          start = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          err;
    logic [15:0]   words_loaded;

    imem_loader #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          abort = 0;
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          last_we_cyc = -1;
    int          rise_cyc = -1;
    logic        prev_core = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/release monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (core_rst_n && !prev_core) rise_cyc = cyc;
        prev_core = core_rst_n;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present one byte (after an optional idle gap) and wait until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (abort) return;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_accept_timeout: s_ready got 0 expected 1 (t=%0t)", $time);
            abort   = 1;
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    // Build a frame of n random words; corrupt flips the checksum.
    task automatic make_frame(input logic [15:0] n, input bit corrupt, output bq_t f);
        logic [7:0] x;
        f = {};
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        if (32'(n) > MAXW) return;
        for (int i = 0; i < 4 * int'(n); i++) f.push_back(8'($urandom));
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    endtask

    // Send a frame and check the outcome against the frame-level model.
    task automatic run_frame(input bq_t f, input int gap_max, input string tag);
        logic [15:0] n;
        bit          len_err;
        int          consumed;
        logic [7:0]  x;
        bit          exp_done;
        int          exp_words;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        int          nw;

        n        = {f[1], f[0]};
        len_err  = (32'(n) > MAXW);
        consumed = len_err ? 2 : (2 + 4 * int'(n) + 1);
        exp_done = 0;
        exp_words = 0;
        if (!len_err) begin
            x = 8'h00;
            for (int i = 0; i < consumed - 1; i++) x = x ^ f[i];
            exp_done  = (f[consumed - 1] == x);
            exp_words = int'(n);
            for (int k = 0; k < int'(n); k++) begin
                exp_addr.push_back(BASE + 32'(4 * k));
                exp_data.push_back({f[2 + 4*k + 3], f[2 + 4*k + 2], f[2 + 4*k + 1], f[2 + 4*k]});
            end
        end

        cap_addr    = {};
        cap_data    = {};
        last_we_cyc = -1;
        rise_cyc    = -1;
        abort       = 0;
        for (int i = 0; i < consumed; i++) begin
            send_byte(f[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        s_valid = 1'b0;
        #1;
        check({tag, ".done"}, done, exp_done);
        check({tag, ".err"}, err, !exp_done);
        check({tag, ".core_rst_n"}, core_rst_n, exp_done);
        check({tag, ".s_ready_after"}, s_ready, 0);
        check({tag, ".words_loaded"}, words_loaded, exp_words);

        @(negedge clk);
        #1;
        check({tag, ".done_held"}, done, exp_done);
        check({tag, ".n_writes"}, cap_addr.size(), exp_addr.size());
        nw = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
        for (int k = 0; k < nw; k++) begin
            check($sformatf("%s.addr[%0d]", tag, k), cap_addr[k], exp_addr[k]);
            check($sformatf("%s.data[%0d]", tag, k), cap_data[k], exp_data[k]);
        end
        if (exp_done && exp_words > 0) begin
            check({tag, ".release_after_last_write"}, (rise_cyc > last_we_cyc), 1);
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, ".start.core_rst_n"}, core_rst_n, 0);
        check({tag, ".start.done"}, done, 0);
        check({tag, ".start.err"}, err, 0);
        check({tag, ".start.s_ready"}, s_ready, 1);
        check({tag, ".start.words_loaded"}, words_loaded, 0);
    endtask

    vec_t vecs[5];
    bq_t  fr;

    initial begin
        // N=2 reference frame; checksum 8'hC2.
        vecs[0] = '{11, 88'hC2_00_10_00_93_00_50_00_13_00_02, 0, 1, 0, 2,
                    32'h0050_0013, 32'h0010_0093};
        vecs[1] = '{3, 88'h00_00_00, 0, 1, 0, 0, 32'h0, 32'h0};
        vecs[2] = '{11, 88'h3D_00_10_00_93_00_50_00_13_00_02, 0, 0, 1, 2,
                    32'h0050_0013, 32'h0010_0093};
        vecs[3] = '{2, 88'h04_01, 0, 0, 1, 0, 32'h0, 32'h0};
        vecs[4] = '{11, 88'hC2_00_10_00_93_00_50_00_13_00_02, 5, 1, 0, 2,
                    32'h0050_0013, 32'h0010_0093};

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst.s_ready", s_ready, 0);
        check("rst.imem_we", imem_we, 0);
        check("rst.imem_addr", imem_addr, BASE);
        check("rst.imem_wdata", imem_wdata, 0);
        check("rst.core_rst_n", core_rst_n, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.words_loaded", words_loaded, 0);
        rst = 1'b1;
        #1;
        check("rst_release.s_ready_low", s_ready, 0);
        @(negedge clk);
        #1;
        check("rst_release.s_ready_high", s_ready, 1);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            fr = {};
            for (int i = 0; i < vecs[v].nbytes; i++) fr.push_back(vecs[v].bytes[8*i +: 8]);
            run_frame(fr, vecs[v].gap_max, $sformatf("vec%0d", v));
            check($sformatf("vec%0d.tbl_done", v), done, vecs[v].exp_done);
            check($sformatf("vec%0d.tbl_err", v), err, vecs[v].exp_err);
            check($sformatf("vec%0d.tbl_words", v), words_loaded, vecs[v].exp_words);
            if (vecs[v].exp_words >= 2 && cap_data.size() >= 2) begin
                check($sformatf("vec%0d.tbl_w0", v), cap_data[0], vecs[v].exp_w0);
                check($sformatf("vec%0d.tbl_w1", v), cap_data[1], vecs[v].exp_w1);
                check($sformatf("vec%0d.tbl_a1", v), cap_addr[1], BASE + 32'h4);
            end
            pulse_start($sformatf("vec%0d", v));
        end

        // Reset mid-frame after 5 data bytes, then a fresh N=1 frame.
        abort = 0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 0);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst.s_ready", s_ready, 0);
        check("midrst.core_rst_n", core_rst_n, 0);
        check("midrst.words_loaded", words_loaded, 0);
        check("midrst.imem_we", imem_we, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.release_s_ready_low", s_ready, 0);
        @(negedge clk);
        #1;
        check("midrst.release_s_ready_high", s_ready, 1);
        make_frame(16'd1, 0, fr);
        run_frame(fr, 0, "midrst_n1");
        pulse_start("midrst_n1");

        // Largest accepted length.
        make_frame(16'(MAXW), 0, fr);
        run_frame(fr, 0, "maxw");
        pulse_start("maxw");

        // Randomized frames.
        for (int r = 0; r < 15; r++) begin
            logic [15:0] n;
            if ($urandom_range(0, 5) == 0) n = 16'(MAXW + 1 + $urandom_range(0, 60000));
            else n = 16'($urandom_range(0, 5));
            make_frame(n, ($urandom_range(0, 3) == 0), fr);
            run_frame(fr, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
            pulse_start($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
